// File: rtl/doa_smoother.sv
// Post-processing of weightblock (bnum, doa) results: ring history, outlier rejection,
// flush on a sustained jump, and a moving-average DOA with a stability flag.
module doa_smoother #(
  parameter int DEPTH       = 8,
  parameter int OUTLIER_TOL = 20,
  parameter int MAX_REJECT  = 3,
  parameter int DOA_MAX     = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       done,
  input  logic [5:0] bnum,
  input  logic [7:0] doa,
  output logic [7:0] avg_doa,
  output logic [5:0] beam,
  output logic       avg_valid,
  output logic       rejected,
  output logic       stable,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = 8 + AW;
  localparam int RW = $clog2(MAX_REJECT + 1);
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {IDLE, EVAL, UPDATE} state_t;
  typedef enum logic [1:0] {D_INVALID, D_ACCEPT, D_REJECT, D_FLUSH} dec_t;

  state_t                 state;
  dec_t                   dec_q, dec_next;
  logic [5:0]             s_bnum, beam_r;
  logic [7:0]             s_doa;
  logic [DEPTH-1:0][7:0]  hist;
  logic [SW-1:0]          sum;
  logic [AW-1:0]          wr_ptr;
  logic [AW:0]            fill_cnt;
  logic [RW-1:0]          rej_cnt;
  logic [CW-1:0]          run_cnt;
  logic                   pend;
  logic                   full;
  logic [7:0]             avg_cur;

  function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? -d : d;
  endfunction

  assign full    = (fill_cnt == (AW+1)'(DEPTH));
  assign avg_cur = sum[SW-1:AW];
  assign busy    = (state != IDLE);

  always_comb begin
    dec_next = D_ACCEPT;
    if (s_doa > 8'(DOA_MAX))
      dec_next = D_INVALID;
    else if (!full)
      dec_next = D_ACCEPT;
    else if (abs_diff(s_doa, avg_cur) <= 9'(OUTLIER_TOL))
      dec_next = D_ACCEPT;
    else if (rej_cnt < RW'(MAX_REJECT))
      dec_next = D_REJECT;
    else
      dec_next = D_FLUSH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dec_q     <= D_INVALID;
      s_bnum    <= '0;
      s_doa     <= '0;
      hist      <= '0;
      sum       <= '0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      rej_cnt   <= '0;
      run_cnt   <= '0;
      beam_r    <= '0;
      pend      <= 1'b0;
      avg_doa   <= '0;
      beam      <= '0;
      avg_valid <= 1'b0;
      rejected  <= 1'b0;
      stable    <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      rejected  <= 1'b0;
      pend      <= 1'b0;
      // Publish one cycle after UPDATE so outputs reflect the post-update history
      if (pend) begin
        avg_valid <= (dec_q != D_INVALID) && full;
        rejected  <= (dec_q == D_INVALID) || (dec_q == D_REJECT);
        if ((dec_q != D_INVALID) && full)
          avg_doa <= avg_cur;
        beam      <= beam_r;
        stable    <= full && (run_cnt >= CW'(2*DEPTH));
      end
      case (state)
        IDLE: begin
          if (done) begin
            s_bnum <= bnum;
            s_doa  <= doa;
            state  <= EVAL;
          end
        end
        EVAL: begin
          dec_q <= dec_next;
          state <= UPDATE;
        end
        UPDATE: begin
          pend  <= 1'b1;
          state <= IDLE;
          case (dec_q)
            D_ACCEPT: begin
              // Slots not yet written hold 0, so the fill phase subtracts nothing
              sum          <= sum + SW'(s_doa) - SW'(hist[wr_ptr]);
              hist[wr_ptr] <= s_doa;
              wr_ptr       <= wr_ptr + 1'b1;
              fill_cnt     <= full ? fill_cnt : fill_cnt + 1'b1;
              run_cnt      <= (run_cnt >= CW'(2*DEPTH)) ? run_cnt : run_cnt + 1'b1;
              rej_cnt      <= '0;
              beam_r       <= s_bnum;
            end
            D_REJECT: begin
              rej_cnt <= rej_cnt + 1'b1;
              run_cnt <= '0;
            end
            D_FLUSH: begin
              hist     <= '0;
              hist[0]  <= s_doa;
              sum      <= SW'(s_doa);
              wr_ptr   <= AW'(1);
              fill_cnt <= (AW+1)'(1);
              rej_cnt  <= '0;
              run_cnt  <= CW'(1);
              beam_r   <= s_bnum;
            end
            default: begin
              run_cnt <= '0;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_doa_smoother.sv
// Bench for doa_smoother: queue-based reference model checked every cycle, plus literal pins.
module tb_doa_smoother;

  logic       clk = 1'b0;
  logic       reset;
  logic       done;
  logic [5:0] bnum;
  logic [7:0] doa;
  logic [7:0] avg_doa;
  logic [5:0] beam;
  logic       avg_valid, rejected, stable, busy;

  doa_smoother dut (
    .clk(clk), .reset(reset), .done(done), .bnum(bnum), .doa(doa),
    .avg_doa(avg_doa), .beam(beam), .avg_valid(avg_valid),
    .rejected(rejected), .stable(stable), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0, total_cnt = 0;
  int checking = 0;
  int valid_seen = 0;

  // Reference model: accepted history as a queue, oldest first
  int q[$];
  int m_rej = 0, m_run = 0, m_beam = 0;
  int cur_avg = 0, cur_beam = 0, cur_stable = 0;
  int pend_valid = 0, pend_rej = 0, pend_avg = 0, pend_beam = 0, pend_stable = 0;
  int exp_at = -1, cap_cyc = -100;

  function automatic void check(string name, int act, int want);
    total_cnt++;
    if (act == want) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
  endfunction

  function automatic int qsum();
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_rej = 0; m_run = 0; m_beam = 0;
    cur_avg = 0; cur_beam = 0; cur_stable = 0;
    exp_at = -1; cap_cyc = -100;
  endfunction

  function automatic void model_sample(int b, int d);
    int avg, diff;
    pend_valid = 0; pend_rej = 0; pend_avg = cur_avg;
    if (d > 180) begin
      pend_rej = 1;
      m_run = 0;
    end else if (q.size() < 8) begin
      q.push_back(d);
      m_beam = b;
      m_run = (m_run < 16) ? m_run + 1 : 16;
      if (q.size() == 8) begin
        pend_valid = 1;
        pend_avg = qsum() / 8;
      end
    end else begin
      avg = qsum() / 8;
      diff = (d > avg) ? d - avg : avg - d;
      if (diff <= 20) begin
        void'(q.pop_front());
        q.push_back(d);
        m_rej = 0;
        m_run = (m_run < 16) ? m_run + 1 : 16;
        m_beam = b;
        pend_valid = 1;
        pend_avg = qsum() / 8;
      end else if (m_rej < 3) begin
        m_rej++;
        m_run = 0;
        pend_valid = 1;
        pend_rej = 1;
        pend_avg = avg;
      end else begin
        q.delete();
        q.push_back(d);
        m_rej = 0;
        m_run = 1;
        m_beam = b;
      end
    end
    pend_beam = m_beam;
    pend_stable = (q.size() == 8 && m_run >= 16) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    int ev, er, eb;
    if (checking != 0) begin
      ev = 0; er = 0;
      if (cyc == exp_at) begin
        ev = pend_valid;
        er = pend_rej;
        if (pend_valid != 0) cur_avg = pend_avg;
        cur_beam = pend_beam;
        cur_stable = pend_stable;
      end
      eb = (cyc == cap_cyc || cyc == cap_cyc + 1) ? 1 : 0;
      if (avg_valid) valid_seen++;
      check("avg_valid", avg_valid, ev);
      check("rejected", rejected, er);
      check("avg_doa", avg_doa, cur_avg);
      check("beam", beam, cur_beam);
      check("stable", stable, cur_stable);
      check("busy", busy, eb);
    end
  end

  task automatic send(input int b, input int d);
    @(negedge clk);
    bnum = 6'(b); doa = 8'(d); done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
    model_sample(b, d);
    cap_cyc = cyc;
    exp_at = cyc + 3;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; done = 1'b0; bnum = '0; doa = '0;
    repeat (3) @(negedge clk);
    check("rst_avg_doa", avg_doa, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    checking = 1;

    // Fill with 90
    valid_seen = 0;
    for (int i = 0; i < 8; i++) send(12, 90);
    check("fill_pulses", valid_seen, 1);
    check("fill_avg", avg_doa, 90);
    check("fill_beam", beam, 12);
    check("fill_stable", stable, 0);

    // Alternating 91/90 wraps the ring; sum tops out at 724
    for (int i = 0; i < 8; i++) send(12, (i % 2 == 0) ? 91 : 90);
    check("wrap_avg", avg_doa, 90);
    check("wrap_stable", stable, 1);

    // Outliers with an invalid sample in the middle
    send(33, 150);
    send(33, 150);
    send(34, 200);
    send(33, 150);
    check("rej_avg", avg_doa, 90);
    check("rej_stable", stable, 0);
    check("rej_beam", beam, 12);
    valid_seen = 0;
    send(33, 150);
    check("flush_no_valid", valid_seen, 0);
    for (int i = 0; i < 7; i++) send(35, 150);
    check("refill_avg", avg_doa, 150);
    check("refill_beam", beam, 35);
    check("refill_pulses", valid_seen, 1);

    // Overrun: second strobe while busy must be dropped
    @(negedge clk);
    bnum = 6'd20; doa = 8'd152; done = 1'b1;
    @(posedge clk);
    #1;
    model_sample(20, 152);
    cap_cyc = cyc;
    exp_at = cyc + 3;
    @(negedge clk);
    bnum = 6'd21; doa = 8'd30;
    @(posedge clk);
    #1;
    done = 1'b0;
    valid_seen = 0;
    repeat (6) @(negedge clk);
    check("overrun_pulses", valid_seen, 1);
    check("overrun_beam", beam, 20);
    check("overrun_avg", avg_doa, 150);

    // Reset while the FSM is in EVAL
    @(negedge clk);
    bnum = 6'd5; doa = 8'd77; done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_avg_doa", avg_doa, 0);
    check("async_beam", beam, 0);
    check("async_avg_valid", avg_valid, 0);
    check("async_rejected", rejected, 0);
    check("async_stable", stable, 0);
    check("async_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    valid_seen = 0;
    for (int i = 0; i < 8; i++) send(3, 40);
    check("post_rst_pulses", valid_seen, 1);
    check("post_rst_avg", avg_doa, 40);
    check("post_rst_beam", beam, 3);

    checking = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
